// File: rtl/arm_pipe_pkg.sv
// Shared definitions for the ARM-style IF/ID pipeline boundary.
// Holds the datapath width, the bubble instruction and the fetch entry layout.
package arm_pipe_pkg;

  localparam int DW = 32;

  // mov r0,r0: the bubble that ID decodes when nothing has been fetched
  localparam logic [31:0] NOP = 32'hE1A0_0000;

  typedef struct packed {
    logic [DW-1:0] pc;
    logic [DW-1:0] instruction;
  } fetch_entry_t;

endpackage

// File: rtl/fifo_regfile.sv
// Storage array for the fetch queue: one write port, one asynchronous read port.
// Contents are cleared on reset so the read port never returns X.
module fifo_regfile #(
  parameter  int DEPTH = 4,
  parameter  int W     = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_fetch_queue.sv
// IF->ID decoupling queue: buffers {pc, instruction} pairs, presents the oldest
// to ID, freezes IF when full and discards everything on a taken branch.
module if_id_fetch_queue
  import arm_pipe_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int DW    = arm_pipe_pkg::DW,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_valid,
  input  logic [DW-1:0] pc_in,
  input  logic [DW-1:0] instruction_in,
  input  logic          branch_taken,
  input  logic          id_stall,
  output logic          freeze,
  output logic          id_valid,
  output logic [DW-1:0] id_pc,
  output logic [DW-1:0] id_instruction,
  output logic [CW-1:0] count
);

  localparam logic [DW-1:0] NOP_W     = DW'(NOP);
  localparam logic [AW-1:0] LAST_SLOT = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count_q;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic [2*DW-1:0] head;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // A full queue refuses the word even if ID pops this cycle; IF is frozen and re-presents it.
  assign push = if_valid & ~full & ~branch_taken;
  assign pop  = ~empty & ~id_stall & ~branch_taken;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (branch_taken) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  fifo_regfile #(
    .DEPTH (DEPTH),
    .W     (2 * DW)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({pc_in, instruction_in}),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Everything below comes from registered state only, so IF sees no input->freeze path.
  assign freeze         = full;
  assign id_valid       = ~empty;
  assign id_pc          = empty ? '0    : head[2*DW-1:DW];
  assign id_instruction = empty ? NOP_W : head[DW-1:0];
  assign count          = count_q;

endmodule
